uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one UART transmitter among NREQ requesters.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between requesters, the round-robin arbiter and the shared UART transmitter.
// The master modport is the client/transmitter side; the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int dBits = 8
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       reqValid;
    logic [NREQ*dBits-1:0] reqData;
    logic [NREQ-1:0]       reqReady;
    logic                  txStart;
    logic [dBits-1:0]      txData;
    logic                  txDone;
    logic                  busy;
    logic [GW-1:0]         grantId;
    logic                  timeoutErr;

    modport master (
        output reqValid, reqData, txDone,
        input  reqReady, txStart, txData, busy, grantId, timeoutErr
    );

    modport slave (
        input  reqValid, reqData, txDone,
        output reqReady, txStart, txData, busy, grantId, timeoutErr
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters, with a
// watchdog that abandons a frame whose txDone never arrives. All outputs are registered.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int dBits   = 8,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              tx_start_q, tx_start_d;
    logic [dBits-1:0]  tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              timeout_err_q, timeout_err_d;
    logic [31:0]       timer_q, timer_d;

    logic              found;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     idx_w;
    int                idx;
    logic              timeout_hit;

    // Search starts one past the last grant, so the pointer only moves when a grant is made.
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        idx    = 0;
        idx_w  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(grant_q) + k) % NREQ;
            idx_w = GW'(idx);
            if (!found && bus.reqValid[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the same pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            grant_q       <= GW'(NREQ - 1);
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            grant_q       <= grant_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (bus.txDone || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Computes next values for the output registers; txDone outranks the watchdog in WAIT.
    always_comb begin
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        busy_d        = (state_d != IDLE);
        grant_d       = grant_q;
        timeout_err_d = 1'b0;
        timer_d       = '0;
        if (state_q == IDLE && found) begin
            req_ready_d[winner] = 1'b1;
            tx_start_d          = 1'b1;
            tx_data_d           = dBits'(bus.reqData >> (int'(winner) * dBits));
            grant_d             = winner;
        end
        if (state_q == WAIT && !bus.txDone) begin
            if (timeout_hit) timeout_err_d = 1'b1;
            else             timer_d       = timer_q + 32'd1;
        end
    end

    assign bus.reqReady   = req_ready_q;
    assign bus.txStart    = tx_start_q;
    assign bus.txData     = tx_data_q;
    assign bus.busy       = busy_q;
    assign bus.grantId    = grant_q;
    assign bus.timeoutErr = timeout_err_q;
endmodule
